ram_word_writer: RTL

- Write-side master for the 32x8 multi-port RAM.
- Accepts 32-bit words over a valid/ready handshake and serializes each into four byte writes on the RAM's 8-bit synchronous write port.
- Byte order is little-endian: byte 0 goes to the lowest address, matching the RAM's 4-word read packing.
- Also provides a fill mode that sequentially writes every RAM location. This is the write-side counterpart of the RAM's address-cycling read mode.

---
 rtl/ram_word_writer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ram_word_writer.sv
// Write-side master for the 32x8 RAM: splits 32-bit words into four
// little-endian byte writes, and can fill the whole memory with a ramp.
module ram_word_writer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [4*DATA_WIDTH-1:0] in_data,
   input  logic [ADDR_WIDTH-1:0]   in_addr,
   input  logic                    fill_start,
   input  logic [DATA_WIDTH-1:0]   fill_value,
   output logic                    wr_en,
   output logic [ADDR_WIDTH-1:0]   w_s,
   output logic [DATA_WIDTH-1:0]   w_d,
   output logic                    busy,
   output logic                    done
);

   localparam int DW = DATA_WIDTH;
   localparam int AW = ADDR_WIDTH;
   localparam logic [AW:0] CNT_ONE  = 1;
   localparam logic [AW:0] FILL_END = {1'b1, {AW{1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      FILL
   } state_t;

   state_t          state_q, state_d;
   logic [4*DW-1:0] word_q,  word_d;
   logic [AW-1:0]   base_q,  base_d;
   logic [DW-1:0]   seed_q,  seed_d;
   logic [1:0]      idx_q,   idx_d;
   logic [AW:0]     cnt_q,   cnt_d;
   logic            wr_en_d;
   logic            done_d;
   logic [AW-1:0]   w_s_d;
   logic [DW-1:0]   w_d_d;
   logic            accept;

   assign in_ready = (state_q == IDLE) & ~fill_start & reset_n;
   assign accept   = in_valid & in_ready;
   assign busy     = (state_q != IDLE);

   // Each branch emits the write for the current step directly into
   // the output registers, so the first byte appears right after accept.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      base_d  = base_q;
      seed_d  = seed_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      wr_en_d = 1'b0;
      done_d  = 1'b0;
      w_s_d   = w_s;
      w_d_d   = w_d;
      unique case (state_q)
         IDLE: begin
            if (fill_start) begin
               state_d = FILL;
               seed_d  = fill_value;
               cnt_d   = CNT_ONE;
               wr_en_d = 1'b1;
               w_s_d   = '0;
               w_d_d   = fill_value;
            end else if (accept) begin
               state_d = BURST;
               word_d  = in_data;
               base_d  = {in_addr[AW-1:2], 2'b00};
               idx_d   = 2'd1;
               wr_en_d = 1'b1;
               w_s_d   = {in_addr[AW-1:2], 2'b00};
               w_d_d   = in_data[DW-1:0];
            end
         end
         BURST: begin
            // idx wraps to 0 once byte 3 has been issued
            if (idx_q == 2'd0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               wr_en_d = 1'b1;
               w_s_d   = {base_q[AW-1:2], idx_q};
               w_d_d   = word_q[DW*idx_q +: DW];
               idx_d   = idx_q + 2'd1;
            end
         end
         FILL: begin
            if (cnt_q == FILL_END) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               wr_en_d = 1'b1;
               w_s_d   = cnt_q[AW-1:0];
               w_d_d   = seed_q + DW'(cnt_q);
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         word_q  <= '0;
         base_q  <= '0;
         seed_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         wr_en   <= 1'b0;
         done    <= 1'b0;
         w_s     <= '0;
         w_d     <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         base_q  <= base_d;
         seed_q  <= seed_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         wr_en   <= wr_en_d;
         done    <= done_d;
         w_s     <= w_s_d;
         w_d     <= w_d_d;
      end
   end

endmodule
